// File: rtl/pdm_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : pdm_frame_sched_if
// Purpose  : Sample handshake and PDM duty/status bundle between the
//            equalizer/testbench side (master) and the frame scheduler (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pdm_frame_sched_if;
  logic        en;
  logic        smpl_vld;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        smpl_rdy;
  logic [15:0] lft_duty;
  logic [15:0] rght_duty;
  logic        active;
  logic        underrun;

  // Sample source / observer side
  modport master (
    output en, smpl_vld, lft_in, rght_in,
    input  smpl_rdy, lft_duty, rght_duty, active, underrun
  );

  // Frame scheduler side
  modport slave (
    input  en, smpl_vld, lft_in, rght_in,
    output smpl_rdy, lft_duty, rght_duty, active, underrun
  );
endinterface
`default_nettype wire

// File: rtl/pdm_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : pdm_frame_sched
// Purpose  : One-frame sample buffer, per-frame tick, ramped soft-mute gain
//            and offset-binary duty generation for a stereo PDM stage.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_frame_sched #(
  parameter int TICK_DIV  = 1024,
  parameter int GAIN_STEP = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pdm_frame_sched_if.slave   bus
);

  localparam int         CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [8:0] c_GAIN_FS = 9'd256;

  typedef enum logic [1:0] {
    ST_MUTE = 2'd0,
    ST_UP   = 2'd1,
    ST_RUN  = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [8:0]         r_gain;
  logic [8:0]         w_gain_nxt;
  logic [9:0]         w_gain_sum;
  logic [8:0]         w_gain_up;
  logic [8:0]         w_gain_dn;

  logic [CNT_W-1:0]   r_count;
  logic               w_tick;
  logic               r_tick_d;

  logic               r_full;
  logic [15:0]        r_lft_buf;
  logic [15:0]        r_rght_buf;
  logic signed [15:0] r_lft_hold;
  logic signed [15:0] r_rght_hold;

  logic               w_accept;
  logic               w_playing;

  logic signed [25:0] w_prod_l;
  logic signed [25:0] w_prod_r;
  logic [15:0]        w_scaled_l;
  logic [15:0]        w_scaled_r;

  logic [15:0]        r_lft_duty;
  logic [15:0]        r_rght_duty;
  logic               r_underrun;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  assign w_tick    = (r_count == CNT_W'(TICK_DIV - 1));
  assign w_playing = (r_state != ST_MUTE);

  // Ready is forced low while reset is held so no pair can be taken then.
  assign w_accept  = bus.smpl_vld & ~r_full & ~rst;

  // Saturating gain steps; the sum is one bit wider so the clamp sees overflow.
  assign w_gain_sum = {1'b0, r_gain} + 10'(GAIN_STEP);
  assign w_gain_up  = (w_gain_sum > {1'b0, c_GAIN_FS}) ? c_GAIN_FS : w_gain_sum[8:0];
  assign w_gain_dn  = (r_gain < 9'(GAIN_STEP)) ? 9'd0 : (r_gain - 9'(GAIN_STEP));

  // Signed sample times zero-extended gain; full-scale gain of 256 is unity
  // after the 8-bit arithmetic shift, so the 16-bit truncation cannot wrap.
  assign w_prod_l   = 26'(r_lft_hold)  * 26'($signed({1'b0, r_gain}));
  assign w_prod_r   = 26'(r_rght_hold) * 26'($signed({1'b0, r_gain}));
  assign w_scaled_l = 16'(w_prod_l >>> 8);
  assign w_scaled_r = 16'(w_prod_r >>> 8);

  assign bus.smpl_rdy  = ~r_full & ~rst;
  assign bus.lft_duty  = r_lft_duty;
  assign bus.rght_duty = r_rght_duty;
  assign bus.active    = w_playing;
  assign bus.underrun  = r_underrun;

  // Free-running frame counter; tick marks its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_tick_d <= 1'b0;
    end else begin
      r_count  <= w_tick ? '0 : (r_count + CNT_W'(1));
      r_tick_d <= w_tick;
    end
  end

  // Single-entry frame buffer plus hold register; MUTE drains without keeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 1'b0;
      r_lft_buf   <= '0;
      r_rght_buf  <= '0;
      r_lft_hold  <= '0;
      r_rght_hold <= '0;
    end else begin
      if (w_tick && r_full) begin
        r_full <= 1'b0;
        if (w_playing) begin
          r_lft_hold  <= $signed(r_lft_buf);
          r_rght_hold <= $signed(r_rght_buf);
        end
      end else if (w_accept) begin
        r_full     <= 1'b1;
        r_lft_buf  <= bus.lft_in;
        r_rght_buf <= bus.rght_in;
      end
    end
  end

  // Gain ramp state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MUTE;
      r_gain  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
    end
  end

  // Direction follows en every cycle; the gain itself only moves on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    case (r_state)
      ST_MUTE: begin
        w_gain_nxt = 9'd0;
        if (bus.en) w_state_nxt = ST_UP;
      end
      ST_UP: begin
        if (w_tick) w_gain_nxt = w_gain_up;
        if (!bus.en)                              w_state_nxt = ST_DOWN;
        else if (w_tick && w_gain_up == c_GAIN_FS) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_gain_nxt = c_GAIN_FS;
        if (!bus.en) w_state_nxt = ST_DOWN;
      end
      ST_DOWN: begin
        if (w_tick) w_gain_nxt = w_gain_dn;
        if (bus.en)                          w_state_nxt = ST_UP;
        else if (w_tick && w_gain_dn == 9'd0) w_state_nxt = ST_MUTE;
      end
      default: begin
        w_state_nxt = ST_MUTE;
        w_gain_nxt  = 9'd0;
      end
    endcase
  end

  // Duty words refresh one cycle after the tick, once hold and gain settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lft_duty  <= 16'h8000;
      r_rght_duty <= 16'h8000;
    end else if (r_tick_d) begin
      r_lft_duty  <= {~w_scaled_l[15], w_scaled_l[14:0]};
      r_rght_duty <= {~w_scaled_r[15], w_scaled_r[14:0]};
    end
  end

  // Underrun pulse: a playing tick that found nothing new to play.
  always_ff @(posedge clk) begin
    if (rst) r_underrun <= 1'b0;
    else     r_underrun <= w_tick & ~r_full & w_playing;
  end

endmodule
`default_nettype wire

// File: tb/tb_pdm_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_frame_sched
// Purpose  : Directed, scoreboard-checked bench for pdm_frame_sched
//            (TICK_DIV=8, GAIN_STEP=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_frame_sched;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        u;
    logic        a;
  } exp_t;

  logic clk;
  logic rst;
  int   tb_cnt;
  int   n_vec;
  int   n_err;
  exp_t q[$];

  pdm_frame_sched_if bus();

  pdm_frame_sched #(
    .TICK_DIV  (8),
    .GAIN_STEP (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame phase reference: 0..7, tick at phase 7
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 7) ? 0 : tb_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: underrun/active checked on T+1, duties popped on T+2,
  // duties otherwise required to hold the last expected value.
  initial begin : monitor
    exp_t        e;
    logic [15:0] hl;
    logic [15:0] hr;
    hl = 16'h8000;
    hr = 16'h8000;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        hl = 16'h8000;
        hr = 16'h8000;
      end else begin
        if (tb_cnt == 0 && q.size() > 0) begin
          chk("underrun", {31'd0, bus.underrun}, {31'd0, q[0].u});
          chk("active",   {31'd0, bus.active},   {31'd0, q[0].a});
        end else begin
          chk("underrun_idle", {31'd0, bus.underrun}, 32'd0);
        end
        if (tb_cnt == 1 && q.size() > 0) begin
          e  = q.pop_front();
          hl = e.l;
          hr = e.r;
        end
        chk("lft_duty",  {16'd0, bus.lft_duty},  {16'd0, hl});
        chk("rght_duty", {16'd0, bus.rght_duty}, {16'd0, hr});
      end
    end
  end

  // One frame, entered at phase 0 just after the negedge; returns at next phase 0.
  task automatic frame(input bit send, input logic [15:0] l, input logic [15:0] r,
                       input bit en_v, input logic [15:0] el, input logic [15:0] er,
                       input bit eu, input bit ea);
    exp_t e;
    int   guard;
    bus.en = en_v;
    if (send) begin
      chk("rdy_before", {31'd0, bus.smpl_rdy}, 32'd1);
      bus.smpl_vld = 1'b1;
      bus.lft_in   = l;
      bus.rght_in  = r;
      @(posedge clk);
      #1 bus.smpl_vld = 1'b0;
      @(negedge clk);
      chk("rdy_drop", {31'd0, bus.smpl_rdy}, 32'd0);
    end
    guard = 0;
    while (tb_cnt != 7 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: got no tick expected tick within 20 cycles");
    end
    if (send) chk("rdy_held", {31'd0, bus.smpl_rdy}, 32'd0);
    e.l = el; e.r = er; e.u = eu; e.a = ea;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int guard;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.smpl_vld = 1'b0;
    bus.lft_in = 16'h0000;
    bus.rght_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",   {31'd0, bus.smpl_rdy},  32'd0);
    chk("rst_lduty", {16'd0, bus.lft_duty},  32'h8000);
    chk("rst_rduty", {16'd0, bus.rght_duty}, 32'h8000);
    rst = 1'b0;
    #1;
    chk("rel_rdy",    {31'd0, bus.smpl_rdy},  32'd1);
    chk("rel_active", {31'd0, bus.active},    32'd0);
    chk("rel_under",  {31'd0, bus.underrun},  32'd0);
    chk("rel_lduty",  {16'd0, bus.lft_duty},  32'h8000);

    // Muted: pair drained, silence, no underrun
    frame(1, 16'h4000, 16'h1234, 0, 16'h8000, 16'h8000, 0, 0);
    // Ramp up by 64 per frame
    frame(1, 16'h4000, 16'hC000, 1, 16'h9000, 16'h7000, 0, 1);
    frame(1, 16'h4000, 16'hC000, 1, 16'hA000, 16'h6000, 0, 1);
    frame(1, 16'h4000, 16'hC000, 1, 16'hB000, 16'h5000, 0, 1);
    frame(1, 16'h4000, 16'hC000, 1, 16'hC000, 16'h4000, 0, 1);
    // Full-gain mapping
    frame(1, 16'h7FFF, 16'h8000, 1, 16'hFFFF, 16'h0000, 0, 1);
    frame(1, 16'h8000, 16'h7FFF, 1, 16'h0000, 16'hFFFF, 0, 1);
    frame(1, 16'h0000, 16'hFFFF, 1, 16'h8000, 16'h7FFF, 0, 1);
    frame(1, 16'hFFFF, 16'h0000, 1, 16'h7FFF, 16'h8000, 0, 1);
    // Underrun repeats previous hold, then normal resume
    frame(0, 16'h0000, 16'h0000, 1, 16'h7FFF, 16'h8000, 1, 1);
    frame(1, 16'h2000, 16'h1000, 1, 16'hA000, 16'h9000, 0, 1);
    // Ramp down to mute
    frame(1, 16'h4000, 16'h4000, 0, 16'hB000, 16'hB000, 0, 1);
    frame(1, 16'h4000, 16'h4000, 0, 16'hA000, 16'hA000, 0, 1);
    frame(1, 16'h4000, 16'h4000, 0, 16'h9000, 16'h9000, 0, 1);
    frame(1, 16'h4000, 16'h4000, 0, 16'h8000, 16'h8000, 0, 0);
    // Reversal at gain 128
    frame(1, 16'h4000, 16'h4000, 1, 16'h9000, 16'h9000, 0, 1);
    frame(1, 16'h4000, 16'h4000, 1, 16'hA000, 16'hA000, 0, 1);
    frame(1, 16'h4000, 16'h4000, 0, 16'h9000, 16'h9000, 0, 1);
    frame(1, 16'h4000, 16'h4000, 1, 16'hA000, 16'hA000, 0, 1);

    // Reset mid-ramp with a pair buffered
    bus.smpl_vld = 1'b1;
    bus.lft_in   = 16'h4000;
    bus.rght_in  = 16'h4000;
    @(posedge clk);
    #1 bus.smpl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_rdy", {31'd0, bus.smpl_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy",    {31'd0, bus.smpl_rdy},  32'd1);
    chk("mid_rel_active", {31'd0, bus.active},    32'd0);
    chk("mid_rel_under",  {31'd0, bus.underrun},  32'd0);
    chk("mid_rel_lduty",  {16'd0, bus.lft_duty},  32'h8000);
    chk("mid_rel_rduty",  {16'd0, bus.rght_duty}, 32'h8000);
    // No stale pair: first playing tick must underrun with zero hold
    frame(0, 16'h0000, 16'h0000, 1, 16'h8000, 16'h8000, 1, 1);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0 pending", q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdm_frame_sched.md
# pdm_frame_sched

Frame scheduler and soft-mute controller for the stereo PDM output stage. It accepts signed left/right audio samples from the equalizer over a valid/ready handshake and buffers one frame. On each audio-frame tick it applies a ramped gain and presents offset-binary duty words to the two PDM modulators, so that mute and unmute transitions are free of pops.

## Interface
- TICK_DIV, 1024: clock cycles per audio frame. Must be 2 or greater.
- GAIN_STEP, 1: gain increment/decrement applied per tick while ramping. Range 1..256.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  level; 1 = unmute (ramp to full gain), 0 = mute (ramp to zero)
- smpl_vld  in  1  sample pair valid
- lft_in  in  16  signed left sample
- rght_in  in  16  signed right sample
- smpl_rdy  out  1  frame buffer empty; can accept a sample pair
- lft_duty  out  16  unsigned duty word to left PDM modulator
- rght_duty  out  16  unsigned duty word to right PDM modulator
- active  out  1  state is not MUTE
- underrun  out  1  one-cycle pulse: a tick found the buffer empty while active

## Operation
- **Tick counter**
  - Free-running, counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` is asserted in the cycle where count == TICK_DIV-1.
- **Frame buffer**
  - One entry: a left/right pair plus a full flag.
  - smpl_rdy = ~full.
  - Accept on smpl_vld & smpl_rdy. The pair is captured and full is set.
  - A tick with full set consumes the pair: it is copied to the hold register and full is cleared.
  - Accept and consume cannot occur in the same cycle.
  - smpl_vld while full is ignored. The upstream block holds the data.
- **Gain**
  - 9-bit unsigned value, 0..256.
  - Updates only on tick, in UP and DOWN.
  - UP: gain = min(gain+GAIN_STEP, 256).
  - DOWN: gain = max(gain-GAIN_STEP, 0).
- **State machine.** Transitions are evaluated every cycle; gain steps only on tick.
  - MUTE: gain = 0. en=1 -> UP.
  - UP: en=0 -> DOWN. If the gain update makes gain 256 -> RUN.
  - RUN: gain = 256. en=0 -> DOWN.
  - DOWN: en=1 -> UP, starting from the current gain. If the gain update makes gain 0 -> MUTE.
- **Duty arithmetic** (per channel)
  - prod = hold (signed 16) × {0,gain} (signed 10) -> 26-bit signed.
  - scaled = prod >>> 8, truncated to 16 bits; this cannot overflow for gain ≤ 256.
  - duty = scaled with MSB inverted, i.e. +0x8000 mod 2^16. 0x8000 is silence.
- **Underrun**
  - A tick in UP, RUN or DOWN with the buffer empty reuses the previous hold value and pulses underrun.
  - A tick in MUTE drains the buffer if full, discards the pair and never pulses underrun.
- **active** is a combinational decode of state != MUTE.

## Timing
- **Reset values** (while rst=1 and the cycle after release):
  - count = 0, full = 0, hold = 0, gain = 0, state = MUTE.
  - lft_duty = rght_duty = 0x8000, underrun = 0, active = 0.
  - smpl_rdy = 0 while rst=1; 1 the cycle after release.
- **Handshake**
  - Transfer on the edge where smpl_vld & smpl_rdy.
  - smpl_rdy drops the next cycle.
  - smpl_rdy returns the cycle after the consuming tick edge.
- **Pipeline**, tick in cycle T:
  - hold, gain and state register at the end of T.
  - lft_duty/rght_duty register at the end of T+1 and are stable for the frame.
  - underrun is registered, high during T+1 only.
  - Duty outputs change only in cycle T+2 relative to a tick.
- **en** is sampled every cycle.
  - A toggle mid-ramp reverses direction on the next edge with no gain jump.
  - A pulse shorter than one frame can leave gain unchanged.
- **Reset mid-ramp or mid-transfer:** all state returns to reset values on that edge. Any buffered pair is lost.

## Test plan
- **Reset, buffer, mute.** Reset 3 cycles with TICK_DIV=8.
  - Required: duty = 0x8000, smpl_rdy = 1 after release.
  - Send lft=0x4000 with en=0. Required: smpl_rdy low until the next tick, duty stays 0x8000, no underrun.
- **Full-gain mapping.** en=1, GAIN_STEP=256.
  - After one tick, state = RUN.
  - Required outputs for lft = 0x7FFF, 0x8000, 0x0000, 0xFFFF: lft_duty = 0xFFFF, 0x0000, 0x8000, 0x7FFF respectively, two cycles after the consuming tick.
- **Ramp up/down.** GAIN_STEP=64, constant lft=0x4000 every frame.
  - en=1: lft_duty over successive frames = 0x9000, 0xA000, 0xB000, 0xC000, then RUN.
  - en=0: lft_duty steps back to 0x8000 and active falls once gain reaches 0.
- **Reversal.** Toggle en 1->0 at gain 128.
  - Required: next tick gives gain 64 (state DOWN); en back to 1 gives 128 on the following tick.
- **Underrun.** In RUN, withhold one sample.
  - Required: underrun high for exactly one cycle; duty repeats the previous value; the next sample resumes normally.
- **Reset mid-ramp** with a buffered pair.
  - Required: all outputs return to reset values; no stale pair appears after release.
